// File: rtl/cordic_bus_regs.sv
// Host register block for the CORDIC controller: operand/control shadows,
// captured results, sticky interrupt, and a single-outstanding request/response port.
module cordic_bus_regs #(
   parameter int                 p_WIDTH      = 32,
   parameter int                 p_ADDR_WIDTH = 3,
   parameter logic [p_WIDTH-1:0] p_CTRL_RESET = 32'h00011FF0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    reqValid,
   output logic                    reqReady,
   input  logic                    reqWrite,
   input  logic [p_ADDR_WIDTH-1:0] reqAddr,
   input  logic [p_WIDTH-1:0]      reqWdata,
   output logic                    rspValid,
   input  logic                    rspReady,
   output logic [p_WIDTH-1:0]      rspRdata,
   output logic                    rspError,
   output logic [p_WIDTH-1:0]      controlRegisterInput,
   output logic [p_WIDTH-1:0]      xInput,
   output logic [p_WIDTH-1:0]      yInput,
   output logic [p_WIDTH-1:0]      zInput,
   input  logic [p_WIDTH-1:0]      controlRegisterOutput,
   input  logic [p_WIDTH-1:0]      xResult,
   input  logic [p_WIDTH-1:0]      yResult,
   input  logic [p_WIDTH-1:0]      zResult,
   input  logic                    controlRegisterWriteEnable,
   input  logic                    interrupt,
   output logic                    irq
);

   localparam logic [p_ADDR_WIDTH-1:0] A_CTRL = p_ADDR_WIDTH'(0);
   localparam logic [p_ADDR_WIDTH-1:0] A_XIN  = p_ADDR_WIDTH'(1);
   localparam logic [p_ADDR_WIDTH-1:0] A_YIN  = p_ADDR_WIDTH'(2);
   localparam logic [p_ADDR_WIDTH-1:0] A_ZIN  = p_ADDR_WIDTH'(3);
   localparam logic [p_ADDR_WIDTH-1:0] A_XRES = p_ADDR_WIDTH'(4);
   localparam logic [p_ADDR_WIDTH-1:0] A_YRES = p_ADDR_WIDTH'(5);
   localparam logic [p_ADDR_WIDTH-1:0] A_ZRES = p_ADDR_WIDTH'(6);
   localparam logic [p_ADDR_WIDTH-1:0] A_STAT = p_ADDR_WIDTH'(7);

   logic [p_WIDTH-1:0] ctrl_r;
   logic [p_WIDTH-1:0] xIn_r;
   logic [p_WIDTH-1:0] yIn_r;
   logic [p_WIDTH-1:0] zIn_r;
   logic [p_WIDTH-1:0] xRes_r;
   logic [p_WIDTH-1:0] yRes_r;
   logic [p_WIDTH-1:0] zRes_r;
   logic               irqPending_r;
   logic               rspValid_r;
   logic [p_WIDTH-1:0] rspRdata_r;
   logic               rspError_r;

   logic               accept_s;
   logic               hostWrite_s;
   logic               ctrlWrite_s;
   logic               statClear_s;
   logic               busy_s;
   logic [p_WIDTH-1:0] ctrlBase_s;
   logic [p_WIDTH-1:0] ctrlNext_s;
   logic [p_WIDTH-1:0] readData_s;
   logic               writeErr_s;

   assign reqReady    = ~rspValid_r | rspReady;
   assign accept_s    = reqValid & reqReady;
   assign hostWrite_s = accept_s & reqWrite;
   assign ctrlWrite_s = hostWrite_s & (reqAddr == A_CTRL);
   assign statClear_s = hostWrite_s & (reqAddr == A_STAT) & reqWdata[0];
   assign busy_s      = ~ctrl_r[16];

   // Next CTRL: controller strobe supplies the base, host may then override the lower half.
   always_comb begin
      ctrlBase_s = controlRegisterWriteEnable ? controlRegisterOutput : ctrl_r;
      ctrlNext_s = ctrlBase_s;
      if (ctrlWrite_s && !busy_s) begin
         ctrlNext_s[15:0] = reqWdata[15:0];
      end else if (ctrlWrite_s && !reqWdata[0]) begin
         ctrlNext_s[1] = reqWdata[1];
      end else begin
         ctrlNext_s[15:0] = ctrlBase_s[15:0];
      end
   end

   // Read mux over pre-edge register contents.
   always_comb begin
      readData_s = {p_WIDTH{1'b0}};
      case (reqAddr)
         A_CTRL:  readData_s = ctrl_r;
         A_XIN:   readData_s = xIn_r;
         A_YIN:   readData_s = yIn_r;
         A_ZIN:   readData_s = zIn_r;
         A_XRES:  readData_s = xRes_r;
         A_YRES:  readData_s = yRes_r;
         A_ZRES:  readData_s = zRes_r;
         A_STAT:  readData_s = {{(p_WIDTH-2){1'b0}}, busy_s, irqPending_r};
         default: readData_s = {p_WIDTH{1'b0}};
      endcase
   end

   // Write rejection: result registers are read-only, START is refused while busy.
   always_comb begin
      writeErr_s = 1'b0;
      case (reqAddr)
         A_XRES, A_YRES, A_ZRES: writeErr_s = reqWrite;
         A_CTRL:                 writeErr_s = reqWrite & busy_s & reqWdata[0];
         default:                writeErr_s = 1'b0;
      endcase
   end

   // Register file, result capture and sticky interrupt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_r       <= p_CTRL_RESET;
         xIn_r        <= {p_WIDTH{1'b0}};
         yIn_r        <= {p_WIDTH{1'b0}};
         zIn_r        <= {p_WIDTH{1'b0}};
         xRes_r       <= {p_WIDTH{1'b0}};
         yRes_r       <= {p_WIDTH{1'b0}};
         zRes_r       <= {p_WIDTH{1'b0}};
         irqPending_r <= 1'b0;
      end else begin
         ctrl_r <= ctrlNext_s;
         if (hostWrite_s && reqAddr == A_XIN) begin
            xIn_r <= reqWdata;
         end
         if (hostWrite_s && reqAddr == A_YIN) begin
            yIn_r <= reqWdata;
         end
         if (hostWrite_s && reqAddr == A_ZIN) begin
            zIn_r <= reqWdata;
         end
         if (controlRegisterWriteEnable) begin
            xRes_r <= xResult;
            yRes_r <= yResult;
            zRes_r <= zResult;
         end
         // A same-edge interrupt beats the W1C.
         irqPending_r <= interrupt | (irqPending_r & ~statClear_s);
      end
   end

   // Response channel: loads on acceptance, drops once the host takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rspValid_r <= 1'b0;
         rspRdata_r <= {p_WIDTH{1'b0}};
         rspError_r <= 1'b0;
      end else if (accept_s) begin
         rspValid_r <= 1'b1;
         rspRdata_r <= reqWrite ? {p_WIDTH{1'b0}} : readData_s;
         rspError_r <= writeErr_s;
      end else if (rspReady) begin
         rspValid_r <= 1'b0;
      end
   end

   assign rspValid             = rspValid_r;
   assign rspRdata             = rspRdata_r;
   assign rspError             = rspError_r;
   assign controlRegisterInput = ctrl_r;
   assign xInput               = xIn_r;
   assign yInput               = yIn_r;
   assign zInput               = zIn_r;
   assign irq                  = irqPending_r;

endmodule

// File: tb/tb_cordic_bus_regs.sv
// Bench for cordic_bus_regs: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a register-map model.
module tb_cordic_bus_regs;

   logic        clk;
   logic        rst;
   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic [2:0]  reqAddr;
   logic [31:0] reqWdata;
   logic        rspValid;
   logic        rspReady;
   logic [31:0] rspRdata;
   logic        rspError;
   logic [31:0] controlRegisterInput;
   logic [31:0] xInput;
   logic [31:0] yInput;
   logic [31:0] zInput;
   logic [31:0] controlRegisterOutput;
   logic [31:0] xResult;
   logic [31:0] yResult;
   logic [31:0] zResult;
   logic        controlRegisterWriteEnable;
   logic        interrupt;
   logic        irq;

   int nChecks = 0;
   int nErrors = 0;

   cordic_bus_regs dut (
      .clk(clk), .rst(rst),
      .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .reqAddr(reqAddr), .reqWdata(reqWdata),
      .rspValid(rspValid), .rspReady(rspReady), .rspRdata(rspRdata), .rspError(rspError),
      .controlRegisterInput(controlRegisterInput),
      .xInput(xInput), .yInput(yInput), .zInput(zInput),
      .controlRegisterOutput(controlRegisterOutput),
      .xResult(xResult), .yResult(yResult), .zResult(zResult),
      .controlRegisterWriteEnable(controlRegisterWriteEnable),
      .interrupt(interrupt), .irq(irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: register map indexed by address ----------------
   logic [31:0] mReg [0:6];
   logic        mPend;
   logic        mRspV;
   logic [31:0] mRd;
   logic        mErr;
   logic        mAcc;
   logic [31:0] mCtrlNext;

   function automatic logic [31:0] mRead(input logic [2:0] a);
      if (a == 3'd7) return {30'd0, ~mReg[0][16], mPend};
      return mReg[a];
   endfunction

   function automatic logic [31:0] ctrlAfter();
      logic [31:0] c;
      c = controlRegisterWriteEnable ? controlRegisterOutput : mReg[0];
      if (mAcc && reqWrite && reqAddr == 3'd0) begin
         if (mReg[0][16]) c[15:0] = reqWdata[15:0];
         else if (!reqWdata[0]) c[1] = reqWdata[1];
      end
      return c;
   endfunction

   function automatic logic writeRejected();
      if (!reqWrite) return 1'b0;
      if (reqAddr >= 3'd4 && reqAddr <= 3'd6) return 1'b1;
      return (reqAddr == 3'd0) && !mReg[0][16] && reqWdata[0];
   endfunction

   assign mAcc      = reqValid && (!mRspV || rspReady);
   assign mCtrlNext = ctrlAfter();

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mReg[0] <= 32'h00011FF0;
         for (int i = 1; i < 7; i++) mReg[i] <= 32'd0;
         mPend <= 1'b0;
         mRspV <= 1'b0;
         mRd   <= 32'd0;
         mErr  <= 1'b0;
      end else begin
         mReg[0] <= mCtrlNext;
         if (mAcc && reqWrite && reqAddr >= 3'd1 && reqAddr <= 3'd3) mReg[reqAddr] <= reqWdata;
         if (controlRegisterWriteEnable) begin
            mReg[4] <= xResult;
            mReg[5] <= yResult;
            mReg[6] <= zResult;
         end
         mPend <= interrupt || (mPend && !(mAcc && reqWrite && reqAddr == 3'd7 && reqWdata[0]));
         if (mAcc) begin
            mRspV <= 1'b1;
            mRd   <= reqWrite ? 32'd0 : mRead(reqAddr);
            mErr  <= writeRejected();
         end else if (rspReady) begin
            mRspV <= 1'b0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("reqReady", {31'd0, reqReady}, {31'd0, !mRspV || rspReady});
         check("rspValid", {31'd0, rspValid}, {31'd0, mRspV});
         check("irq", {31'd0, irq}, {31'd0, mPend});
         check("ctrlIn", controlRegisterInput, mReg[0]);
         check("xIn", xInput, mReg[1]);
         check("yIn", yInput, mReg[2]);
         check("zIn", zInput, mReg[3]);
         if (mRspV) begin
            check("rspRdata", rspRdata, mRd);
            check("rspError", {31'd0, rspError}, {31'd0, mErr});
         end
      end
   end

   // ---------------- directed helpers (called at posedge+2) ----------------
   task automatic hostReq(input logic w, input logic [2:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e);
      reqValid = 1'b1; reqWrite = w; reqAddr = a; reqWdata = d;
      #1;
      check("reqReadyBefore", {31'd0, reqReady}, 32'd1);
      @(posedge clk); #2;
      reqValid = 1'b0;
      check("rspValidAfter", {31'd0, rspValid}, 32'd1);
      rd = rspRdata;
      e  = rspError;
   endtask

   task automatic readExp(input logic [2:0] a, input logic [31:0] exp, input string name);
      logic [31:0] rd;
      logic e;
      hostReq(1'b0, a, 32'd0, rd, e);
      check(name, rd, exp);
      check({name, "Err"}, {31'd0, e}, 32'd0);
   endtask

   task automatic writeExp(input logic [2:0] a, input logic [31:0] d, input logic expErr, input string name);
      logic [31:0] rd;
      logic e;
      hostReq(1'b1, a, d, rd, e);
      check(name, {31'd0, e}, {31'd0, expErr});
      check({name, "Rdata"}, rd, 32'd0);
   endtask

   task automatic setCtrl(input logic [31:0] c, input logic [31:0] x);
      controlRegisterWriteEnable = 1'b1;
      controlRegisterOutput = c; xResult = x; yResult = 32'h11; zResult = 32'h22;
   endtask

   task automatic clrCtrl();
      controlRegisterWriteEnable = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk); #2;
   endtask

   initial begin
      rst = 1'b0;
      reqValid = 1'b0; reqWrite = 1'b0; reqAddr = 3'd0; reqWdata = 32'd0;
      rspReady = 1'b1;
      controlRegisterOutput = 32'd0; xResult = 32'd0; yResult = 32'd0; zResult = 32'd0;
      controlRegisterWriteEnable = 1'b0; interrupt = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      check("rstRspValid", {31'd0, rspValid}, 32'd0);
      check("rstRspRdata", rspRdata, 32'd0);
      check("rstRspError", {31'd0, rspError}, 32'd0);
      check("rstReqReady", {31'd0, reqReady}, 32'd1);
      check("rstCtrl", controlRegisterInput, 32'h00011FF0);

      for (int a = 0; a < 8; a++)
         readExp(3'(a), (a == 0) ? 32'h00011FF0 : 32'd0, "rstRead");

      writeExp(3'd1, 32'h26DD3B6A, 1'b0, "wXin");
      writeExp(3'd2, 32'd0, 1'b0, "wYin");
      writeExp(3'd3, 32'h20000000, 1'b0, "wZin");
      writeExp(3'd0, 32'h00001F25, 1'b0, "wCtrlStart");
      check("xInputLit", xInput, 32'h26DD3B6A);
      check("zInputLit", zInput, 32'h20000000);
      check("ctrlStartLit", controlRegisterInput, 32'h00011F25);

      setCtrl(32'h00001F24, 32'd0); cycle(); clrCtrl();
      readExp(3'd0, 32'h00001F24, "ctrlBusy");
      readExp(3'd7, 32'h00000002, "statBusy");

      writeExp(3'd0, 32'h00001F25, 1'b1, "startWhileBusy");
      readExp(3'd0, 32'h00001F24, "ctrlUnchanged");
      writeExp(3'd0, 32'h00000002, 1'b0, "stopWhileBusy");
      readExp(3'd0, 32'h00001F26, "ctrlStop");
      setCtrl(32'h00001F24, 32'd0); cycle(); clrCtrl();
      readExp(3'd0, 32'h00001F24, "stopCleared");

      setCtrl(32'h07D11F24, 32'h1F4A3C2E); cycle(); clrCtrl();
      interrupt = 1'b1; cycle(); interrupt = 1'b0;
      check("irqSet", {31'd0, irq}, 32'd1);
      readExp(3'd4, 32'h1F4A3C2E, "xres");
      readExp(3'd7, 32'h00000001, "statPend");
      writeExp(3'd7, 32'h00000001, 1'b0, "w1c");
      check("irqCleared", {31'd0, irq}, 32'd0);
      readExp(3'd7, 32'h00000000, "statClear");

      interrupt = 1'b1;
      writeExp(3'd7, 32'h00000001, 1'b0, "w1cRace");
      interrupt = 1'b0;
      check("irqSetWins", {31'd0, irq}, 32'd1);
      readExp(3'd7, 32'h00000001, "statSetWins");
      writeExp(3'd7, 32'h00000001, 1'b0, "w1cAgain");

      setCtrl(32'h0000ABCD, 32'd0);
      writeExp(3'd0, 32'h00001235, 1'b0, "mixReady");
      clrCtrl();
      readExp(3'd0, 32'h00001235, "ctrlMixReady");
      setCtrl(32'h00015555, 32'd0);
      writeExp(3'd0, 32'h00000002, 1'b0, "mixBusy");
      clrCtrl();
      readExp(3'd0, 32'h00015557, "ctrlMixBusy");
      writeExp(3'd5, 32'h12345678, 1'b1, "roWrite");

      begin
         logic [31:0] rd;
         logic e;
         hostReq(1'b0, 3'd1, 32'd0, rd, e);
         rspReady = 1'b0;
         check("holdFirst", rd, 32'h26DD3B6A);
         reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 3'd1; reqWdata = 32'hDEADBEEF;
         for (int i = 0; i < 3; i++) begin
            cycle();
            check("holdReqReady", {31'd0, reqReady}, 32'd0);
            check("holdRspValid", {31'd0, rspValid}, 32'd1);
            check("holdRdata", rspRdata, 32'h26DD3B6A);
         end
         check("holdNoWrite", xInput, 32'h26DD3B6A);
         #1 rst = 1'b1;
         #1;
         check("midRstRspValid", {31'd0, rspValid}, 32'd0);
         check("midRstReqReady", {31'd0, reqReady}, 32'd1);
         check("midRstXin", xInput, 32'd0);
         check("midRstCtrl", controlRegisterInput, 32'h00011FF0);
         reqValid = 1'b0; rspReady = 1'b1;
         cycle();
         rst = 1'b0;
         readExp(3'd4, 32'd0, "postRstXres");
      end

      for (int n = 0; n < 4000; n++) begin
         reqValid = ($urandom_range(0, 3) != 0);
         reqWrite = $urandom_range(0, 1) == 1;
         reqAddr  = 3'($urandom_range(0, 7));
         reqWdata = $urandom;
         rspReady = ($urandom_range(0, 3) != 0);
         controlRegisterWriteEnable = ($urandom_range(0, 4) == 0);
         controlRegisterOutput = $urandom;
         xResult = $urandom; yResult = $urandom; zResult = $urandom;
         interrupt = ($urandom_range(0, 9) == 0);
         rst = (n == 2000);
         cycle();
      end
      rst = 1'b0;
      reqValid = 1'b0; controlRegisterWriteEnable = 1'b0; interrupt = 1'b0;
      cycle();
      @(negedge clk); #1;

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
